// File: rtl/cpu7_excp_ctl_pkg.sv
// cpu7_excp_ctl_pkg: exccode constants and redirect FSM state encoding for cpu7_excp_ctl
package cpu7_excp_ctl_pkg;
  localparam logic [5:0] EXC_INT = 6'h00;
  localparam logic [5:0] EXC_INE = 6'h0D;
  localparam logic [5:0] EXC_SYS = 6'h0B;
  localparam logic [5:0] EXC_BRK = 6'h0C;
  localparam logic [5:0] EXC_ALE = 6'h09;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1, QUIET = 2'd2} state_t;
endpackage

// File: rtl/cpu7_excp_ctl_sync2.sv
// cpu7_sync2: two-flop synchronizer, both flops cleared by sync active-high reset
module cpu7_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk) begin
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
  end
endmodule

// File: rtl/cpu7_excp_ctl.sv
// cpu7_excp_ctl: _e-stage exception/interrupt prioritisation, flush and IFU redirect; CPU7_EXT_INTR_SYNC_EN adds a 2-flop ext_intr synchronizer
`ifndef GRLEN
`define GRLEN 32
`endif
module cpu7_excp_ctl
  import cpu7_excp_ctl_pkg::*;
#(
  parameter int GRLEN = `GRLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ecl_valid_e,
  input  logic [GRLEN-1:0] ecl_pc_e,
  input  logic             ecl_ine_e,
  input  logic             ecl_sys_e,
  input  logic             ecl_brk_e,
  input  logic             ecl_ale_e,
  input  logic             ecl_ertn_e,
  input  logic [GRLEN-1:0] lsu_badaddr_e,
  input  logic             csr_ecl_crmd_ie,
  input  logic             csr_ecl_timer_intr,
  input  logic             ext_intr,
  input  logic [GRLEN-1:0] csr_eentry,
  input  logic [GRLEN-1:0] csr_era,
  input  logic             ifu_exu_redirect_ack,
  output logic             exu_ifu_except,
  output logic [5:0]       ecl_csr_exccode_e,
  output logic [GRLEN-1:0] lsu_csr_badv_e,
  output logic             ecl_csr_ertn_e,
  output logic             exu_ifu_redirect,
  output logic [GRLEN-1:0] exu_ifu_redirect_pc,
  output logic             ecl_flush
);
  state_t state;
  logic [GRLEN-1:0] held_pc;
  logic ext_intr_s, intr_req, idle, take, ertn_take, ev;
`ifdef CPU7_EXT_INTR_SYNC_EN
  cpu7_sync2 u_sync (.clk(clk), .rst(rst), .d(ext_intr), .q(ext_intr_s));
`else
  assign ext_intr_s = ext_intr;
`endif
  assign idle = state == IDLE;
  assign intr_req = csr_ecl_crmd_ie & (csr_ecl_timer_intr | ext_intr_s);
  assign take = ecl_valid_e & idle & (intr_req | ecl_ine_e | ecl_sys_e | ecl_brk_e | ecl_ale_e);
  assign ertn_take = ecl_valid_e & ecl_ertn_e & idle & ~take;
  assign ev = take | ertn_take;
  assign exu_ifu_except = take;
  assign ecl_csr_ertn_e = ertn_take;
  assign ecl_csr_exccode_e = !take ? 6'h00 : intr_req ? EXC_INT : ecl_ine_e ? EXC_INE :
                             ecl_sys_e ? EXC_SYS : ecl_brk_e ? EXC_BRK : EXC_ALE;
  // badaddr only when misalignment is the winning cause
  assign lsu_csr_badv_e = !take ? '0 :
                          (intr_req | ecl_ine_e | ecl_sys_e | ecl_brk_e) ? ecl_pc_e : lsu_badaddr_e;
  assign exu_ifu_redirect = ev | (state == WAIT_ACK);
  assign exu_ifu_redirect_pc = (state == WAIT_ACK) ? held_pc : take ? csr_eentry :
                               ertn_take ? csr_era : '0;
  assign ecl_flush = ev | ~idle;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      held_pc <= '0;
    end else begin
      state <= idle ? (ev ? (ifu_exu_redirect_ack ? QUIET : WAIT_ACK) : IDLE) :
               (state == WAIT_ACK) ? (ifu_exu_redirect_ack ? QUIET : WAIT_ACK) : IDLE;
      held_pc <= ev ? (take ? csr_eentry : csr_era) : held_pc;
    end
  end
endmodule

// File: tb/tb_cpu7_excp_ctl.sv
// tb_cpu7_excp_ctl: directed stimulus checked every cycle against a behavioural model plus literal expectations
module tb_cpu7_excp_ctl;
`ifdef CPU7_EXT_INTR_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  localparam int LAT = SYNC ? 2 : 0;
  localparam logic [31:0] EENTRY = 32'h1C00_0100;
  localparam logic [31:0] ERA = 32'h0000_0400;
  logic clk = 0, rst = 1;
  logic valid = 0, ine = 0, sys = 0, brk = 0, ale = 0, ertn = 0;
  logic ie = 0, timer = 0, ext = 0, ack = 1;
  logic [31:0] pc = 0, badaddr = 0, eentry = EENTRY, era = ERA;
  logic except, ertn_o, redirect, flush;
  logic [5:0] exccode;
  logic [31:0] badv, rpc;
  int errs = 0, checks = 0;
  logic m_wait = 0, m_quiet = 0, n_wait, n_quiet;
  logic [31:0] m_tgt = 0, n_tgt;
  logic [1:0] m_hist = 0, n_hist;
  always #5 clk = ~clk;
  cpu7_excp_ctl dut (
    .clk(clk), .rst(rst), .ecl_valid_e(valid), .ecl_pc_e(pc),
    .ecl_ine_e(ine), .ecl_sys_e(sys), .ecl_brk_e(brk), .ecl_ale_e(ale), .ecl_ertn_e(ertn),
    .lsu_badaddr_e(badaddr), .csr_ecl_crmd_ie(ie), .csr_ecl_timer_intr(timer), .ext_intr(ext),
    .csr_eentry(eentry), .csr_era(era), .ifu_exu_redirect_ack(ack),
    .exu_ifu_except(except), .ecl_csr_exccode_e(exccode), .lsu_csr_badv_e(badv),
    .ecl_csr_ertn_e(ertn_o), .exu_ifu_redirect(redirect), .exu_ifu_redirect_pc(rpc),
    .ecl_flush(flush)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  // model: compare this cycle's outputs, then work out the post-edge model state
  task automatic model_check();
    logic ext_s, idle, intr, tk, et;
    logic c[5];
    int codes[5] = '{0, 13, 11, 12, 9};
    int code;
    ext_s = SYNC ? m_hist[1] : ext;
    idle = !m_wait && !m_quiet;
    intr = ie & (timer | ext_s);
    c = '{intr, ine, sys, brk, ale};
    code = 0;
    for (int i = 4; i >= 0; i--) if (c[i]) code = codes[i];
    tk = valid & idle & (intr | ine | sys | brk | ale);
    et = valid & ertn & idle & !tk;
    chk("m_except", {31'b0, except}, {31'b0, tk});
    chk("m_exccode", {26'b0, exccode}, tk ? code : 0);
    chk("m_badv", badv, !tk ? 32'h0 : (code == 9) ? badaddr : pc);
    chk("m_ertn", {31'b0, ertn_o}, {31'b0, et});
    chk("m_redirect", {31'b0, redirect}, {31'b0, tk | et | m_wait});
    chk("m_rpc", rpc, m_wait ? m_tgt : tk ? eentry : et ? era : 32'h0);
    chk("m_flush", {31'b0, flush}, {31'b0, tk | et | !idle});
    n_wait = m_wait; n_quiet = m_quiet; n_tgt = m_tgt;
    n_hist = {m_hist[0], ext};
    if (rst) begin
      n_wait = 0; n_quiet = 0; n_tgt = 0; n_hist = 0;
    end else if (idle && (tk || et)) begin
      n_tgt = tk ? eentry : era;
      n_wait = !ack; n_quiet = ack;
    end else if (m_wait && ack) begin
      n_wait = 0; n_quiet = 1;
    end else if (m_quiet) n_quiet = 0;
  endtask
  task automatic settle(); #3; endtask
  task automatic adv();
    model_check();
    @(posedge clk);
    m_wait = n_wait; m_quiet = n_quiet; m_tgt = n_tgt; m_hist = n_hist;
    #1;
  endtask
  task automatic clr();
    valid = 0; ine = 0; sys = 0; brk = 0; ale = 0; ertn = 0;
    ie = 0; timer = 0; ext = 0; ack = 1;
  endtask
  initial begin
    int lat;
    @(posedge clk); #1;
    settle();
    chk("rst_redirect", {31'b0, redirect}, 0);
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_except", {31'b0, except}, 0);
    adv();
    rst = 0;
    settle(); adv();
    valid = 1; ale = 1; badaddr = 32'h1003; pc = 32'h200;
    settle();
    chk("ale_except", {31'b0, except}, 1);
    chk("ale_code", {26'b0, exccode}, 32'h09);
    chk("ale_badv", badv, 32'h1003);
    chk("ale_rpc", rpc, EENTRY);
    adv();
    settle();
    chk("quiet_except", {31'b0, except}, 0);
    chk("quiet_flush", {31'b0, flush}, 1);
    chk("quiet_redirect", {31'b0, redirect}, 0);
    adv();
    clr();
    settle();
    chk("idle_flush", {31'b0, flush}, 0);
    adv();
    valid = 1; ine = 1; sys = 1; pc = 32'h300;
    settle();
    chk("ine_code", {26'b0, exccode}, 32'h0D);
    chk("ine_badv", badv, 32'h300);
    adv(); clr(); settle(); adv();
    valid = 1; ie = 1; timer = 1; brk = 1; pc = 32'h340;
    settle();
    chk("int_code", {26'b0, exccode}, 32'h00);
    chk("int_except", {31'b0, except}, 1);
    adv();
    settle();
    chk("int_no_nest", {31'b0, except}, 0);
    adv(); clr(); settle(); adv();
    ack = 0; valid = 1; ertn = 1;
    settle();
    chk("ertn_pulse", {31'b0, ertn_o}, 1);
    chk("ertn_rpc", rpc, ERA);
    adv();
    era = 32'h999;
    for (int i = 0; i < 3; i++) begin
      ack = (i == 2);
      settle();
      chk("ertn_hold_redir", {31'b0, redirect}, 1);
      chk("ertn_hold_rpc", rpc, ERA);
      chk("ertn_once", {31'b0, ertn_o}, 0);
      adv();
    end
    valid = 0; ertn = 0; era = ERA;
    settle();
    chk("ertn_quiet_redir", {31'b0, redirect}, 0);
    chk("ertn_quiet_flush", {31'b0, flush}, 1);
    adv(); clr();
    valid = 1; ext = 1; pc = 32'h500;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ie0_no_take", {31'b0, except}, 0);
      adv();
    end
    ext = 0; ie = 1;
    settle(); adv(); settle(); adv();
    ext = 1;
    lat = -1;
    for (int i = 0; i < 6 && lat < 0; i++) begin
      settle();
      if (except) lat = i;
      adv();
    end
    chk("ext_latency", lat, LAT);
    clr(); settle(); adv(); settle(); adv();
    ack = 0; valid = 1; sys = 1;
    settle(); adv();
    clr(); ack = 0;
    settle();
    chk("wait_redirect", {31'b0, redirect}, 1);
    rst = 1;
    adv();
    rst = 0;
    settle();
    chk("rst_wait_redirect", {31'b0, redirect}, 0);
    chk("rst_wait_flush", {31'b0, flush}, 0);
    adv();
    ack = 1; valid = 1; ertn = 1;
    settle();
    chk("post_rst_ertn", {31'b0, ertn_o}, 1);
    adv(); clr(); settle(); adv(); settle(); adv();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cpu7_excp_ctl.md
# cpu7_excp_ctl

Exception/interrupt control at the _e stage of the cpu7 pipeline. The block collects per-instruction fault flags and interrupt requests, prioritises them, and drives the commit-side controls that the CSR block latches: exception pulse, exccode, BADV value, and ertn pulse. It also owns the pipeline flush and the fetch redirect handshake toward the IFU, plus a one-cycle blackout so an interrupt cannot be taken again before CRMD.IE has updated.

## Interface
Parameters:
- GRLEN, default `GRLEN (32): data/address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ecl_valid_e  in  1  valid instruction in _e.
- ecl_pc_e  in  GRLEN  PC of the _e instruction.
- ecl_ine_e, ecl_sys_e, ecl_brk_e, ecl_ale_e, ecl_ertn_e  in  1 each  per-instruction flags (illegal, syscall, break, misaligned, ertn).
- lsu_badaddr_e  in  GRLEN  faulting address for ALE.
- csr_ecl_crmd_ie  in  1  global interrupt enable.
- csr_ecl_timer_intr  in  1  timer interrupt level.
- ext_intr  in  1  external interrupt level (asynchronous when sync is enabled).
- csr_eentry, csr_era  in  GRLEN  redirect targets.
- ifu_exu_redirect_ack  in  1  IFU accepted redirect.
- exu_ifu_except  out  1  exception taken (1-cycle pulse).
- ecl_csr_exccode_e  out  6  exccode, valid with except.
- lsu_csr_badv_e  out  GRLEN  BADV value, valid with except.
- ecl_csr_ertn_e  out  1  ertn committed (1-cycle pulse).
- exu_ifu_redirect  out  1  redirect request.
- exu_ifu_redirect_pc  out  GRLEN  redirect target.
- ecl_flush  out  1  kill _e and younger instructions.

Reset: every output is 0 and the FSM is in IDLE.

## Operation
Interrupt condition:
- intr_req = csr_ecl_crmd_ie & (csr_ecl_timer_intr | ext_intr_s).
- ext_intr_s is the synchronized or raw ext_intr (see Configuration).

take = ecl_valid_e & state==IDLE & (intr_req | ine | sys | brk | ale).

Priority and exccode, highest first:
- INT 0x00
- INE 0x0D
- SYS 0x0B
- BRK 0x0C
- ALE 0x09

BADV value:
- ALE: lsu_badaddr_e.
- All other causes: ecl_pc_e.

ertn:
- ertn_take = ecl_valid_e & ecl_ertn_e & state==IDLE & ~take.
- Any exception or interrupt suppresses ertn.

Redirect target:
- take: csr_eentry.
- ertn_take: csr_era.
- The target is registered at the event and held until ack.

FSM states: IDLE, WAIT_ACK, QUIET.
- IDLE → QUIET on (take | ertn_take) & ack.
- IDLE → WAIT_ACK on (take | ertn_take) & ~ack.
- WAIT_ACK → QUIET on ack.
- QUIET → IDLE unconditionally after 1 cycle.

Output behaviour by state:
- exu_ifu_redirect = 1 in the event cycle and throughout WAIT_ACK.
- ecl_flush = take | ertn_take | state!=IDLE.
- ecl_valid_e is ignored outside IDLE, so no second event can start.
- QUIET covers the cycle in which the CSR register updates CRMD.IE/PLV. This guarantees no nested interrupt on stale IE.

rst in any state forces IDLE on the next edge and clears the held target.

## Timing
- except, exccode, badv and ertn are combinational from the _e inputs in the event cycle; the CSR block latches them at that edge.
- Redirect latency: 0 cycles (same cycle as the event) when ack is already high.
- Minimum spacing between two events is 2 cycles (event cycle, then QUIET).
- Interrupt latency from ext_intr to take: 2 extra cycles with the synchronizer, 0 without. A valid _e instruction is also required.
- Interrupt levels are not latched here. A request that drops before being taken is lost; the source keeps its line high until cleared.

## Configuration
CPU7_EXT_INTR_SYNC_EN:
- Defined: ext_intr passes through a 2-flop synchronizer. Both flops reset to 0.
- Undefined: ext_intr_s = ext_intr directly, and the source is required to be synchronous to clk.

## Structure
- Shared package/defines header holds:
  - Exccode constants (EXC_INT, EXC_INE, EXC_SYS, EXC_BRK, EXC_ALE).
  - FSM state encoding (2 bits).
- Sub-module cpu7_sync2, a 2-flop synchronizer, is instantiated only under the macro.
- Registers use the existing dff library cells with synchronous active-high reset.

## Test plan
- ale=1, valid=1, badaddr=0x1003, pc=0x200, ack=1 → except pulse, exccode=0x09, badv=0x1003, redirect_pc=eentry, then QUIET then IDLE.
- ine=1 and sys=1 together → exccode=0x0D, badv=pc.
- IE=1, timer_intr=1, brk=1 → exccode=0x00. One cycle later with timer still high → no second take (QUIET).
- ertn=1, ack held low 3 cycles → redirect=1 with pc=era for 4 cycles, flush high throughout, ertn pulse exactly once.
- IE=0, ext_intr=1 → no take. Raise IE → take after the sync delay (2 cycles with the macro, 0 without).
- rst asserted in WAIT_ACK → next cycle redirect=0, flush=0, state IDLE.
